// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: fixed-latency 64-bit word memory target for the core data bus.
// Define DBUS_RESP_RANDOM_STALL_EN to add 0..3 LFSR-driven extra wait cycles per access.
module dbus_mem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [63:0] resp_data,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [63:0]   data_q, data_d;
   logic [7:0]    strb_q, strb_d;
   logic          bad_q, bad_d;
   logic          err_q, err_d;
   logic [63:0]   mem [DEPTH];
   logic [63:0]   off_in;
   logic [3:0]    mask;
   logic          bad_in;
   logic [4:0]    lat;
   assign off_in = req_addr - BASE_ADDR;
   assign mask   = (4'd1 << req_size[1:0]) - 4'd1;
   assign bad_in = (req_size > 3'd3) || ((req_addr[2:0] & mask[2:0]) != 3'd0) ||
                   (req_addr < BASE_ADDR) || (off_in >= (64'(DEPTH) << 3));
`ifdef DBUS_RESP_RANDOM_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign lat    = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign lat = 5'(LATENCY);
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      strb_d  = strb_q;
      bad_d   = bad_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            idx_d   = off_in[AW+2:3];
            data_d  = req_data;
            strb_d  = req_strobe;
            bad_d   = bad_in;
            err_d   = err_q | bad_in;
            cnt_d   = lat;
            state_d = (lat == 5'd0) ? RESP : WAIT;
         end
         // a dropped request is abandoned silently, nothing is written
         WAIT: begin
            cnt_d   = cnt_q - 5'd1;
            state_d = !req_valid ? IDLE : (cnt_q == 5'd1) ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
      end
   end
   // array has no reset; a reset during RESP forces IDLE first so the write is dropped
   always_ff @(posedge clk) begin
      if (state_q == RESP && !bad_q)
         for (int b = 0; b < 8; b++)
            if (strb_q[b]) mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
   end
   assign resp_addr_ok = (state_q == RESP);
   assign resp_data_ok = (state_q == RESP);
   assign resp_data    = (state_q == RESP && !bad_q && strb_q == 8'h00) ? mem[idx_q] : 64'd0;
   assign err          = err_q;
endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder: directed and random accesses checked against a word-array model.
module tb_dbus_mem_responder;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam int DEPTH = 1024;
   localparam int LAT = 2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [63:0] addr = '0;
   logic [2:0]  size = '0;
   logic [7:0]  strobe = '0;
   logic [63:0] data = '0;
   logic        aok, dok, err;
   logic [63:0] rdata;
   logic        b_valid = 1'b0;
   logic [63:0] b_addr = '0;
   logic [2:0]  b_size = '0;
   logic [7:0]  b_strobe = '0;
   logic [63:0] b_data = '0;
   logic        b_aok, b_dok, b_err;
   logic [63:0] b_rdata;
   logic [63:0] mem_m [DEPTH];
   logic        err_m = 1'b0;
   int          tests = 0;
   int          fails = 0;

   dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
      .clk(clk), .rst(rst), .req_valid(valid), .req_addr(addr), .req_size(size),
      .req_strobe(strobe), .req_data(data), .resp_addr_ok(aok), .resp_data_ok(dok),
      .resp_data(rdata), .err(err));

   dbus_mem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(BASE)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_addr(b_addr), .req_size(b_size),
      .req_strobe(b_strobe), .req_data(b_data), .resp_addr_ok(b_aok), .resp_data_ok(b_dok),
      .resp_data(b_rdata), .err(b_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // call and return at #1 after a rising edge; applies the spec's rules to the model
   task automatic acc(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st, input logic [63:0] d);
      logic        bad;
      logic [63:0] exp_d;
      int          idx;
      int          n;
      bit          got;
      bad = (sz > 3) || (a < BASE) || (((a - BASE) / 8) >= 64'(DEPTH)) || ((a % (64'd1 << sz)) != 0);
      idx = bad ? 0 : int'((a - BASE) / 8);
      exp_d = (bad || st != 8'h00) ? 64'd0 : mem_m[idx];
      err_m = err_m | bad;
      addr = a; size = sz; strobe = st; data = d; valid = 1'b1;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (dok) got = 1; else n++;
      end
      chk("latency", 64'(n), 64'(LAT + 1));
      chk("resp_data", rdata, exp_d);
      chk("err", {63'd0, err}, {63'd0, err_m});
      chk("addr_ok", {63'd0, aok}, 64'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      if (!bad)
         for (int b = 0; b < 8; b++)
            if (st[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   initial begin
      @(negedge clk);
      chk("rst_aok", {63'd0, aok}, 64'd0);
      chk("rst_dok", {63'd0, dok}, 64'd0);
      chk("rst_data", rdata, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      acc(64'h8000_0008, 3'd3, 8'hFF, 64'h1122334455667788);
      acc(64'h8000_0008, 3'd3, 8'h00, 64'd0);
      chk("rd_const", rdata, 64'd0);
      acc(64'h8000_000A, 3'd0, 8'h04, 64'h0000_0000_00AB_0000);
      acc(64'h8000_0008, 3'd3, 8'h00, 64'd0);
      chk("byte_merge", mem_m[1], 64'h1122334455AB7788);
      acc(64'h8000_0003, 3'd2, 8'h00, 64'd0);
      acc(64'h8000_000C, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
      acc(64'h8000_0008, 3'd3, 8'h00, 64'd0);
      acc(BASE + 64'(DEPTH) * 8, 3'd3, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE);
      acc(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0);
      acc(64'h8000_0008, 3'd6, 8'h00, 64'd0);
      chk("err_sticky", {63'd0, err}, 64'd1);
      // reset while a write is waiting: the write must be lost
      addr = 64'h8000_0008; size = 3'd3; strobe = 8'hFF; data = 64'h0BAD_0BAD_0BAD_0BAD; valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_err", {63'd0, err}, 64'd0);
      chk("mid_rst_dok", {63'd0, dok}, 64'd0);
      chk("mid_rst_aok", {63'd0, aok}, 64'd0);
      chk("mid_rst_data", rdata, 64'd0);
      valid = 1'b0;
      err_m = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_dok", {63'd0, dok}, 64'd0);
      end
      @(posedge clk); #1;
      acc(64'h8000_0008, 3'd3, 8'h00, 64'd0);
      for (int w = 0; w < 8; w++) acc(BASE + 64'(w) * 8, 3'd3, 8'hFF, {$urandom, $urandom});
      for (int i = 0; i < 40; i++) begin
         logic [63:0] a;
         logic [2:0]  sz;
         logic [7:0]  st;
         int          r;
         r = $urandom_range(0, 9);
         a = BASE + 64'($urandom_range(0, 7)) * 8 + ($urandom_range(0, 1) ? 64'd0 : 64'($urandom_range(0, 7)));
         if (r == 0) a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 7)) * 8;
         if (r == 1) a = BASE - 64'd8;
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         st = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00;
         acc(a, sz, st, {$urandom, $urandom});
      end
      for (int w = 0; w < 8; w++) acc(BASE + 64'(w) * 8, 3'd3, 8'h00, 64'd0);
      // LATENCY=0 instance: valid held high, responses in cycles T+1 and T+3
      b_addr = BASE; b_size = 3'd3; b_strobe = 8'hFF; b_data = 64'h0123_4567_89AB_CDEF; b_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("l0_dok", {63'd0, b_dok}, (n == 1 || n == 3) ? 64'd1 : 64'd0);
      end
      b_valid = 1'b0;
      @(posedge clk); #1;
      b_strobe = 8'h00; b_valid = 1'b1;
      @(negedge clk);
      chk("l0_rd_wait", {63'd0, b_dok}, 64'd0);
      @(negedge clk);
      chk("l0_rd_dok", {63'd0, b_dok}, 64'd1);
      chk("l0_rd_data", b_rdata, 64'h0123_4567_89AB_CDEF);
      chk("l0_err", {63'd0, b_err}, 64'd0);
      b_valid = 1'b0;
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
